pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports: Clk  in  1  rising-edge clock; Rst_n  in  1  synchronous active-low reset.
REQ-002 SHALL have ports: ID_Rs  in  5  and ID_Rt  in  5, the source register fields of the instruction in ID.
REQ-003 SHALL have ports: ID_UsesRt  in  1, meaning ID reads Rt (R-type, store or branch); ID_Beq, ID_Bne, ID_Jump  in  1 each, the ID decode flags.
REQ-004 SHALL have port ID_BranchTaken  in  1, the ID branch compare result, valid only with ID_Beq or ID_Bne.
REQ-005 SHALL have ports: EX_MemRead  in  1; EX_RegWrite  in  1; EX_DestReg  in  5, the resolved EX destination.
REQ-006 SHALL have port Mem_Busy  in  1, meaning the data memory is not ready and MEM must hold.
REQ-007 SHALL have outputs PC_Write  out  1; IFID_Write  out  1; IFID_Flush  out  1; IDEX_Bubble  out  1; Pipe_Freeze  out  1 (hold EX/MEM and MEM/WB).
REQ-008 SHALL have output Stall_Cycles  out  16 only when HAZARD_PERF_CNT_EN is defined.

Function
REQ-009 SHALL implement states RUN, STALL and MEM_WAIT in a registered FSM with a 2-bit down-counter Stall_Cnt.
REQ-010 SHALL compute hazards combinationally, and SHALL never raise a hazard on register 0.
- match_rs = (ID_Rs == EX_DestReg) and ID_Rs != 0
- match_rt = ID_UsesRt and (ID_Rt == EX_DestReg) and ID_Rt != 0
- match = match_rs or match_rt
REQ-011 SHALL flag a load-use hazard when EX_MemRead and match hold; the stall need is 1 cycle, or 2 cycles if ID_Beq or ID_Bne.
REQ-012 SHALL flag a branch-data hazard when EX_RegWrite, not EX_MemRead, match, and ID_Beq or ID_Bne all hold; the stall need is 1 cycle.
REQ-013 SHALL apply priority Mem_Busy > data hazard > control flush.
REQ-014 In any state, Mem_Busy=1 SHALL set Pipe_Freeze=1, PC_Write=0, IFID_Write=0, IDEX_Bubble=0 and IFID_Flush=0, and SHALL move to MEM_WAIT while preserving Stall_Cnt.
REQ-015 MEM_WAIT SHALL return to STALL when Mem_Busy=0 and Stall_Cnt!=0, otherwise to RUN; that exit cycle SHALL evaluate outputs as in the target state.
REQ-016 RUN with a hazard SHALL drive PC_Write=0, IFID_Write=0 and IDEX_Bubble=1; if the need is 2 it SHALL load Stall_Cnt=1 and go to STALL, else it SHALL stay in RUN.
REQ-017 STALL SHALL drive PC_Write=0, IFID_Write=0 and IDEX_Bubble=1, decrement Stall_Cnt, and go to RUN when Stall_Cnt reaches 0.
REQ-018 RUN with no hazard and (ID_Jump or (ID_Beq/ID_Bne and ID_BranchTaken)) SHALL drive IFID_Flush=1 and PC_Write=1 for exactly one cycle.
REQ-019 Any flush request coinciding with a stall or freeze SHALL be suppressed that cycle and re-evaluated once ID advances.
REQ-020 RUN with no event SHALL drive PC_Write=1, IFID_Write=1 and all other outputs 0.
REQ-021 SHALL compute outputs combinationally from state and inputs, with zero added latency.

Reset
REQ-022 Rst_n=0 at a Clk edge SHALL set state=RUN, Stall_Cnt=0 and Stall_Cycles=0, aborting any stall or wait in progress.
REQ-023 While Rst_n=0, outputs SHALL be PC_Write=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1 and Pipe_Freeze=0.

Configuration
REQ-024 SHALL use macro HAZARD_PERF_CNT_EN to select the performance counter.
- Defined: Stall_Cycles increments by 1 each cycle PC_Write=0 with Rst_n=1, saturating at 16'hFFFF.
- Undefined: port and counter are absent; all other behaviour is identical.

Verification
REQ-025 SHALL cover: EX_MemRead=1, EX_DestReg=8, ID_Rs=8, no branch -> one cycle of IDEX_Bubble=1 and PC_Write=0, then PC_Write=1.
REQ-026 SHALL cover: EX_MemRead=1, EX_DestReg=9, ID_Beq=1, ID_Rt=9, ID_UsesRt=1 -> two consecutive stall cycles (RUN then STALL), then RUN.
REQ-027 SHALL cover: EX_RegWrite=1, EX_DestReg=0, ID_Rs=0, ID_Bne=1, ID_BranchTaken=1 -> no stall, and IFID_Flush=1 for one cycle.
REQ-028 SHALL cover: Mem_Busy=1 for 3 cycles during a STALL with Stall_Cnt=1 -> Pipe_Freeze=1 for 3 cycles, then one more stall cycle, then RUN.
REQ-029 SHALL cover: Rst_n=0 asserted mid-STALL -> next edge state=RUN, and Stall_Cycles=0 (macro defined).
REQ-030 SHALL cover: ID_Jump=1 with load-use on Rs -> stall first with IFID_Flush=0, then IFID_Flush=1 on the following cycle.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Hazard and stall controller for a 5-stage in-order pipeline with branches
// resolved in ID. It detects load-use and branch-data hazards between the
// instruction in ID and the one in EX. It inserts bubbles (including a
// two-cycle stall for a branch that depends on a load) and flushes IF/ID on
// taken branches and jumps. It freezes the back end while data memory is busy.
//
// Optional feature: define HAZARD_PERF_CNT_EN to add the Stall_Cycles
// performance counter port.
//
// Ports
//   Clk              in   rising-edge clock
//   Rst_n            in   synchronous active-low reset
//   ID_Rs, ID_Rt     in   [4:0] source register fields of the ID instruction
//   ID_UsesRt        in   ID instruction reads Rt (R-type, store, branch)
//   ID_Beq, ID_Bne   in   ID conditional branch decode flags
//   ID_Jump          in   ID unconditional jump decode flag
//   ID_BranchTaken   in   ID branch compare result (meaningful with Beq/Bne)
//   EX_MemRead       in   EX instruction is a load
//   EX_RegWrite      in   EX instruction writes a register
//   EX_DestReg       in   [4:0] resolved EX destination register
//   Mem_Busy         in   data memory not ready; MEM must hold
//   PC_Write         out  PC update enable
//   IFID_Write       out  IF/ID register write enable
//   IFID_Flush       out  squash the instruction in IF/ID
//   IDEX_Bubble      out  inject a bubble into ID/EX
//   Pipe_Freeze      out  hold EX/MEM and MEM/WB
//   Stall_Cycles     out  [15:0] saturating count of cycles with PC_Write=0
//                         (only with HAZARD_PERF_CNT_EN)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_Beq,
  input  logic        ID_Bne,
  input  logic        ID_Jump,
  input  logic        ID_BranchTaken,
  input  logic        EX_MemRead,
  input  logic        EX_RegWrite,
  input  logic [4:0]  EX_DestReg,
  input  logic        Mem_Busy,
  output logic        PC_Write,
  output logic        IFID_Write,
  output logic        IFID_Flush,
  output logic        IDEX_Bubble,
  output logic        Pipe_Freeze
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [15:0] Stall_Cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STALL    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  state_t     eff_state;
  logic [1:0] stall_cnt_q, stall_cnt_d;

  logic is_branch;
  logic match_rs;
  logic match_rt;
  logic reg_match;
  logic load_use;
  logic branch_data;
  logic hazard;
  logic need_two;
  logic flush_req;

  // ---------------------------------------------------------------------------
  // Hazard detection (purely combinational). Register 0 is hard-wired to zero,
  // so a match on it never creates a dependency.
  // ---------------------------------------------------------------------------
  always_comb begin
    is_branch   = ID_Beq | ID_Bne;
    match_rs    = (ID_Rs == EX_DestReg) && (ID_Rs != 5'd0);
    match_rt    = ID_UsesRt && (ID_Rt == EX_DestReg) && (ID_Rt != 5'd0);
    reg_match   = match_rs | match_rt;
    load_use    = EX_MemRead & reg_match;
    // A branch compares in ID, so even an ALU result in EX is too late.
    branch_data = EX_RegWrite & ~EX_MemRead & reg_match & is_branch;
    hazard      = load_use | branch_data;
    // A branch depending on a load must wait for the load to clear MEM too.
    need_two    = load_use & is_branch;
    flush_req   = ID_Jump | (is_branch & ID_BranchTaken);
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Bubble = 1'b0;
    Pipe_Freeze = 1'b0;

    // The cycle that leaves MEM_WAIT behaves exactly like the state it is
    // returning to, so the wait adds no extra dead cycle.
    eff_state = state_q;
    if (state_q == ST_MEM_WAIT) begin
      eff_state = (stall_cnt_q != 2'd0) ? ST_STALL : ST_RUN;
    end

    if (!Rst_n) begin
      // Hold the front end and keep bubbles flowing while in reset.
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Bubble = 1'b1;
      state_d     = ST_RUN;
      stall_cnt_d = 2'd0;
    end else if (Mem_Busy) begin
      // Whole pipe holds; any pending stall count survives the wait.
      Pipe_Freeze = 1'b1;
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      state_d     = ST_MEM_WAIT;
    end else begin
      state_d = eff_state;
      case (eff_state)
        ST_STALL: begin
          PC_Write    = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          if (stall_cnt_q <= 2'd1) begin
            stall_cnt_d = 2'd0;
            state_d     = ST_RUN;
          end else begin
            stall_cnt_d = stall_cnt_q - 2'd1;
          end
        end
        default: begin
          if (hazard) begin
            // Any flush from the stalled instruction is suppressed here and
            // re-evaluated once it advances out of ID.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            if (need_two) begin
              stall_cnt_d = 2'd1;
              state_d     = ST_STALL;
            end
          end else if (flush_req) begin
            // Redirect the PC and squash the wrong-path fetch in IF/ID.
            IFID_Flush = 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Stall-cycle counter: counts every non-reset cycle the PC is held,
  // sticking at all-ones rather than wrapping.
  // ---------------------------------------------------------------------------
  logic [15:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!PC_Write && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_cycles_q <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign Stall_Cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Scoreboard bench for pipeline_hazard_ctrl. The stimulus process drives one
// input vector per clock and pushes the expected outputs from a behavioural
// model. The model tracks only "stall cycles still owed" as an integer and
// treats the controller as a priority list (reset, memory busy, owed stall,
// new hazard, flush, run). A monitor pops and compares on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [4:0]  ID_Rs = '0;
  logic [4:0]  ID_Rt = '0;
  logic        ID_UsesRt = 1'b0;
  logic        ID_Beq = 1'b0;
  logic        ID_Bne = 1'b0;
  logic        ID_Jump = 1'b0;
  logic        ID_BranchTaken = 1'b0;
  logic        EX_MemRead = 1'b0;
  logic        EX_RegWrite = 1'b0;
  logic [4:0]  EX_DestReg = '0;
  logic        Mem_Busy = 1'b0;
  logic        PC_Write;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Bubble;
  logic        Pipe_Freeze;
`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] Stall_Cycles;
`endif

  pipeline_hazard_ctrl dut (
    .Clk            (Clk),
    .Rst_n          (Rst_n),
    .ID_Rs          (ID_Rs),
    .ID_Rt          (ID_Rt),
    .ID_UsesRt      (ID_UsesRt),
    .ID_Beq         (ID_Beq),
    .ID_Bne         (ID_Bne),
    .ID_Jump        (ID_Jump),
    .ID_BranchTaken (ID_BranchTaken),
    .EX_MemRead     (EX_MemRead),
    .EX_RegWrite    (EX_RegWrite),
    .EX_DestReg     (EX_DestReg),
    .Mem_Busy       (Mem_Busy),
    .PC_Write       (PC_Write),
    .IFID_Write     (IFID_Write),
    .IFID_Flush     (IFID_Flush),
    .IDEX_Bubble    (IDEX_Bubble),
    .Pipe_Freeze    (Pipe_Freeze)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .Stall_Cycles   (Stall_Cycles)
`endif
  );

  always #5 Clk = ~Clk;

  // Expected outputs packed as {PC_Write, IFID_Write, IFID_Flush,
  // IDEX_Bubble, Pipe_Freeze}.
  typedef struct {
    logic [4:0]  outs;
    logic [15:0] cyc;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: stall cycles still owed, and the stall-cycle count.
  int          m_pend = 0;
  logic [15:0] m_cyc  = 16'd0;

  task automatic model_push(input string tag);
    exp_t e;
    bit   br, mrs, mrt, m, fl;
    int   need;
    br   = ID_Beq || ID_Bne;
    mrs  = (ID_Rs == EX_DestReg) && (ID_Rs != 0);
    mrt  = ID_UsesRt && (ID_Rt == EX_DestReg) && (ID_Rt != 0);
    m    = mrs || mrt;
    need = 0;
    if (EX_MemRead && m)                 need = br ? 2 : 1;
    else if (EX_RegWrite && m && br)     need = 1;
    fl   = ID_Jump || (br && ID_BranchTaken);

    e.tag = tag;
    e.cyc = m_cyc;
    if (!Rst_n) begin
      e.outs = 5'b00110;
      m_pend = 0;
    end else if (Mem_Busy) begin
      e.outs = 5'b00001;
    end else if (m_pend > 0) begin
      e.outs = 5'b00010;
      m_pend = m_pend - 1;
    end else if (need > 0) begin
      e.outs = 5'b00010;
      m_pend = need - 1;
    end else if (fl) begin
      e.outs = 5'b11100;
    end else begin
      e.outs = 5'b11000;
    end

    if (!Rst_n)                                   m_cyc = 16'd0;
    else if (!e.outs[4] && m_cyc != 16'hFFFF)     m_cyc = m_cyc + 16'd1;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input string tag, input bit r,
                       input logic [4:0] rs, input logic [4:0] rt, input bit ur,
                       input bit bq, input bit bn, input bit jp, input bit tk,
                       input bit mr, input bit rw, input logic [4:0] dst,
                       input bit bz);
    @(posedge Clk);
    #1;
    Rst_n = r;  ID_Rs = rs;  ID_Rt = rt;  ID_UsesRt = ur;
    ID_Beq = bq;  ID_Bne = bn;  ID_Jump = jp;  ID_BranchTaken = tk;
    EX_MemRead = mr;  EX_RegWrite = rw;  EX_DestReg = dst;  Mem_Busy = bz;
    model_push(tag);
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if ({PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze} === e.outs)
          n_pass++;
        else
          $display("FAIL %s outs{pcw,ifw,flush,bub,frz} got=%b want=%b t=%0t",
                   e.tag, {PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble, Pipe_Freeze},
                   e.outs, $time);
`ifdef HAZARD_PERF_CNT_EN
        n_checks++;
        if (Stall_Cycles === e.cyc)
          n_pass++;
        else
          $display("FAIL %s stall_cycles got=%0d want=%0d t=%0t",
                   e.tag, Stall_Cycles, e.cyc, $time);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    // Reset held for two edges.
    cycle("reset0", 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);
    cycle("reset1", 0, 5'd3, 5'd3, 1, 1, 0, 1, 1, 1, 1, 5'd3, 1);
    cycle("idle",   1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);

    // Load-use on Rs: one bubble then run.
    cycle("lu_rs",      1, 5'd8, 5'd0, 0, 0, 0, 0, 0, 1, 1, 5'd8, 0);
    cycle("lu_rs_go",   1, 5'd8, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);

    // Branch on a loaded Rt: two stall cycles then run.
    cycle("lu_beq_1",   1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 1, 1, 5'd9, 0);
    cycle("lu_beq_2",   1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0);
    cycle("lu_beq_go",  1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0);

    // Register 0 never hazards; taken bne flushes once.
    cycle("r0_bne",     1, 5'd0, 5'd0, 0, 0, 1, 0, 1, 0, 1, 5'd0, 0);
    cycle("r0_after",   1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);

    // Branch-data hazard (ALU result in EX): one stall, then taken flush.
    cycle("bdh",        1, 5'd5, 5'd0, 0, 1, 0, 0, 1, 0, 1, 5'd5, 0);
    cycle("bdh_flush",  1, 5'd5, 5'd0, 0, 1, 0, 0, 1, 0, 0, 5'd0, 0);

    // Rt ignored when the instruction does not read it.
    cycle("rt_unused",  1, 5'd0, 5'd6, 0, 0, 0, 0, 0, 1, 1, 5'd6, 0);

    // Memory busy for three cycles during STALL with one owed cycle.
    cycle("mw_enter",   1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 1, 1, 5'd9, 0);
    cycle("mw_busy1",   1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 0, 0, 5'd0, 1);
    cycle("mw_busy2",   1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 0, 0, 5'd0, 1);
    cycle("mw_busy3",   1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 0, 0, 5'd0, 1);
    cycle("mw_stall",   1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0);
    cycle("mw_run",     1, 5'd0, 5'd9, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0);

    // Busy wins over a hazard in RUN.
    cycle("busy_hz",    1, 5'd4, 5'd0, 0, 0, 1, 0, 1, 1, 1, 5'd4, 1);
    cycle("busy_hz_x",  1, 5'd4, 5'd0, 0, 0, 1, 0, 1, 1, 1, 5'd4, 0);
    cycle("busy_hz_y",  1, 5'd4, 5'd0, 0, 0, 1, 0, 1, 0, 0, 5'd0, 0);
    cycle("busy_hz_z",  1, 5'd4, 5'd0, 0, 0, 1, 0, 1, 0, 0, 5'd0, 0);

    // Reset mid-STALL aborts it.
    cycle("rs_enter",   1, 5'd7, 5'd0, 0, 0, 1, 0, 0, 1, 1, 5'd7, 0);
    cycle("rs_reset",   0, 5'd7, 5'd0, 0, 0, 1, 0, 0, 0, 0, 5'd0, 0);
    cycle("rs_after",   1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);

    // Jump behind a load-use: stall without flush, then flush.
    cycle("jmp_stall",  1, 5'd7, 5'd0, 0, 0, 0, 1, 0, 1, 1, 5'd7, 0);
    cycle("jmp_flush",  1, 5'd7, 5'd0, 0, 0, 0, 1, 0, 0, 0, 5'd0, 0);
    cycle("jmp_after",  1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 0);

    // Randomized traffic with small register indices to provoke matches.
    for (int i = 0; i < 400; i++) begin
      bit bq, bn;
      bq = ($urandom_range(0, 3) == 0);
      bn = !bq && ($urandom_range(0, 3) == 0);
      cycle("rand", ($urandom_range(0, 39) != 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), bq, bn,
            ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 6) == 0));
    end

    @(negedge Clk);
    @(negedge Clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0)
      n_pass++;
    else
      $display("FAIL drain pending_expectations got=%0d want=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
